loop_replay_buffer: RTL and testbench
=====================================

# loop_replay_buffer

Parametrised loop buffer for the fetch front end, successor to the fixed 4-entry loop FSM. It detects a short backward branch loop, captures one full iteration of the loop body into a DEPTH-entry buffer, and then replays it while holding fetch off with `block_signal`. Replay ends in one of two ways:
- a `mispredict` from execute, which flushes and redirects to the fall-through PC;
- an optional iteration limit, which hands fetch back at the loop head.

## Interface
- `XLEN`, 32: width of PC, instruction and immediate.
- `DEPTH`, 8: buffer entries, i.e. the maximum loop body length in instructions. Power of two, ≥ 2.
- `ITER_LIMIT`, 0: full replay iterations before a voluntary exit. 0 means unlimited.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: `curr_PC`, `instruction` and `immediate` are valid this cycle.
- `curr_PC` in XLEN: byte PC of the fetched instruction.
- `instruction` in XLEN: fetched instruction.
- `immediate` in XLEN: signed branch offset in instruction units (target = `curr_PC` + 4·`immediate`).
- `mispredict` in 1: execute reports that the loop branch fell through.
- `block_signal` out 1: fetch stall. High for every REPLAY cycle.
- `flush` out 1: one-cycle pulse on a mispredict exit.
- `redirect` out 1: one-cycle pulse whenever fetch must load `new_pc`.
- `new_pc` out XLEN: PC of the replayed instruction, or the redirect target.
- `out_instruction` out XLEN: instruction delivered to decode.
- `out_valid` out 1: `out_instruction` is valid.

## Operation
**Loop branch.** A valid input is a loop branch when both hold:
- `instruction[6:0]` = 7'b1100011;
- `immediate` is negative, with L = 1 − `immediate` satisfying 2 ≤ L ≤ DEPTH.

**Registers.**
- `head_pc` = `curr_PC` + 4·`immediate`.
- `br_pc`: PC of the loop branch.
- `len` = L.
- `wr_idx` and `rd_idx`: clog2(DEPTH) bits each.
- Iteration counter: 16 bits.

**IDLE**
- Pass-through: `out_instruction`/`out_valid` mirror `instruction`/`in_valid`, registered.
- `block_signal` = 0.
- On a loop branch: latch `head_pc`, `br_pc`, `len`, clear `wr_idx`, then go to CAPTURE.

**CAPTURE** (pass-through continues)
- Each valid input must have `curr_PC` = `head_pc` + 4·`wr_idx`. If so, write `buf[wr_idx]` and increment `wr_idx`.
- Abort to IDLE, with no flush and no redirect, on any of:
  - PC mismatch;
  - `mispredict`;
  - the entry at `wr_idx` = `len`−1 is not identical to the latched branch PC.
- If the abort input is itself a loop branch, it re-arms CAPTURE for the new loop in the same cycle.
- Writing entry `len`−1 (the branch) goes to REPLAY with `rd_idx` = 0 and the iteration counter = 0.
- `in_valid` = 0 cycles hold all state.

**REPLAY**
- Each cycle: `out_instruction` = `buf[rd_idx]`, `new_pc` = `head_pc` + 4·`rd_idx`, `out_valid` = 1, `block_signal` = 1.
- `rd_idx` wraps from `len`−1 to 0; each wrap increments the iteration counter.
- Inputs other than `mispredict` are ignored.
- **Mispredict exit:** on `mispredict`, the next cycle has `flush` = 1, `redirect` = 1, `new_pc` = `br_pc` + 4, `out_valid` = 0, `block_signal` = 0. State becomes IDLE.
- **Limit exit:** when `ITER_LIMIT` ≠ 0 and the counter reaches `ITER_LIMIT` at a wrap, the next cycle has `redirect` = 1, `flush` = 0, `new_pc` = `head_pc`, `out_valid` = 0. State becomes IDLE.
- If `mispredict` and a limit exit fall in the same cycle, the mispredict exit is taken.

**Widths.** `new_pc` arithmetic is modulo 2^XLEN. The shift of `immediate` by 2 is done in XLEN bits.

## Timing
- **Reset:** state IDLE, every output 0, indices and counters 0. The buffer contents need not be cleared. `reset` overrides everything in the same edge, including mid-REPLAY: the next cycle has `block_signal` = 0 and no flush.
- **Pass-through latency:** 1 cycle.
- **Capture to replay:** the cycle after the branch entry is captured, `block_signal` = 1 and `out_instruction` = `buf[0]`.
- **Mispredict:** `mispredict` sampled at edge t gives `flush`/`redirect` high for exactly the cycle after t. Replay output stops in that same cycle.
- **Ordering:** `flush` never coincides with `out_valid` = 1. `redirect` and `block_signal` are never both 1.

## Test plan
- **Capture and replay:** feed 0x100 (0x13), 0x104, 0x108, 0x10C (0xFC000AE3, imm −3) twice. Expect REPLAY; `block_signal` = 1; outputs cycle 0x13, 0x14, 0x15, 0xFC000AE3 with `new_pc` 0x100, 0x104, 0x108, 0x10C.
- **Mispredict exit:** raise `mispredict` for 1 cycle during REPLAY. Expect the next cycle to have `flush` = `redirect` = 1, `new_pc` = 0x110, `block_signal` = 0. A fresh 0x110–0x11C loop then captures and replays correctly.
- **Iteration limit:** with `ITER_LIMIT` = 3, expect exactly 12 replayed instructions, then `redirect` = 1, `flush` = 0, `new_pc` = 0x100.
- **Bounds:** with imm = −DEPTH (L = DEPTH+1), stay in IDLE. With imm = −(DEPTH−1), capture all DEPTH entries and replay with `rd_idx` wrapping at DEPTH−1.
- **Capture abort:** a PC jump to 0x200 mid-capture gives IDLE with no redirect. `in_valid` = 0 gaps during capture still yield an identical replay.
- **Reset and collision:** `reset` mid-REPLAY gives all outputs 0 the next cycle. `mispredict` on the limit-wrap cycle gives `flush` = 1 and `new_pc` = `br_pc` + 4.

Source files
------------

// File: rtl/loop_replay_buffer.sv
// Loop replay buffer: detects a short backward-branch loop, captures one iteration of its body
// and replays it from the buffer while holding fetch off.
module loop_replay_buffer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ITER_LIMIT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] curr_PC,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] immediate,
  input  logic            mispredict,
  output logic            block_signal,
  output logic            flush,
  output logic            redirect,
  output logic [XLEN-1:0] new_pc,
  output logic [XLEN-1:0] out_instruction,
  output logic            out_valid
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StCapture, StReplay} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] head_q, head_d;
  logic [XLEN-1:0] br_q, br_d;
  logic [IW-1:0]   last_q, last_d;  // loop length minus one, i.e. index of the branch entry
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [15:0]     iter_q, iter_d;
  logic            pt_valid_q, pt_valid_d;
  logic [XLEN-1:0] pt_instr_q, pt_instr_d;
  logic            flush_q, flush_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic            we;
  logic            arm;
  logic            abort;
  logic            is_loop_br;
  logic [XLEN-1:0] neg_imm;
  logic [XLEN-1:0] tgt_pc;
  logic [XLEN-1:0] exp_pc;
  logic [XLEN-1:0] rd_pc;

  assign neg_imm    = -immediate;
  assign tgt_pc     = curr_PC + (immediate << 2);
  assign exp_pc     = head_q + (XLEN'(wr_idx_q) << 2);
  assign rd_pc      = head_q + (XLEN'(rd_idx_q) << 2);
  // -imm in [1, DEPTH-1] is the same as 2 <= 1-imm <= DEPTH for a negative offset.
  assign is_loop_br = in_valid && (instruction[6:0] == 7'b1100011) && immediate[XLEN-1] &&
                      (neg_imm <= XLEN'(DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    br_d       = br_q;
    last_d     = last_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    iter_d     = iter_q;
    pt_valid_d = in_valid;
    pt_instr_d = instruction;
    flush_d    = 1'b0;
    redirect_d = 1'b0;
    redir_pc_d = '0;
    we         = 1'b0;
    arm        = 1'b0;
    abort      = 1'b0;

    unique case (state_q)
      StIdle: begin
        arm = is_loop_br;
      end
      StCapture: begin
        abort = mispredict ||
                (in_valid && ((curr_PC != exp_pc) || ((wr_idx_q == last_q) && (curr_PC != br_q))));
        if (abort) begin
          state_d = StIdle;
          arm     = is_loop_br;
        end else if (in_valid) begin
          we = 1'b1;
          if (wr_idx_q == last_q) begin
            state_d  = StReplay;
            rd_idx_d = '0;
            iter_d   = '0;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      StReplay: begin
        pt_valid_d = 1'b0;
        if (mispredict) begin
          state_d    = StIdle;
          flush_d    = 1'b1;
          redirect_d = 1'b1;
          redir_pc_d = br_q + XLEN'(4);
        end else if (rd_idx_q == last_q) begin
          rd_idx_d = '0;
          iter_d   = iter_q + 16'd1;
          if ((ITER_LIMIT != 0) && (iter_d == 16'(ITER_LIMIT))) begin
            state_d    = StIdle;
            redirect_d = 1'b1;
            redir_pc_d = head_q;
          end
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (arm) begin
      state_d  = StCapture;
      head_d   = tgt_pc;
      br_d     = curr_PC;
      last_d   = IW'(neg_imm);
      wr_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      head_q     <= '0;
      br_q       <= '0;
      last_q     <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      iter_q     <= '0;
      pt_valid_q <= 1'b0;
      pt_instr_q <= '0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      br_q       <= br_d;
      last_q     <= last_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      iter_q     <= iter_d;
      pt_valid_q <= pt_valid_d;
      pt_instr_q <= pt_instr_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  // Buffer contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_idx_q] <= instruction;
    end
  end

  assign block_signal    = (state_q == StReplay);
  assign out_valid       = block_signal | pt_valid_q;
  assign out_instruction = block_signal ? mem_q[rd_idx_q] : pt_instr_q;
  assign new_pc          = block_signal ? rd_pc : redir_pc_q;
  assign flush           = flush_q;
  assign redirect        = redirect_q;

endmodule

// File: tb/tb_loop_replay_buffer.sv
// Directed, table-driven bench for loop_replay_buffer (DEPTH 8, ITER_LIMIT 3).
module tb_loop_replay_buffer;

  localparam logic [31:0] Br1 = 32'hFC000AE3;
  localparam logic [31:0] Br2 = 32'hFE000EE3;
  localparam logic [31:0] M3  = 32'hFFFFFFFD;
  localparam logic [31:0] M7  = 32'hFFFFFFF9;
  localparam logic [31:0] M8  = 32'hFFFFFFF8;

  logic        clk = 1'b0;
  logic        reset, in_valid, mispredict;
  logic [31:0] curr_pc, instruction, immediate;
  logic        block_signal, flush, redirect, out_valid;
  logic [31:0] new_pc, out_instruction;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  always #5 clk = ~clk;

  loop_replay_buffer #(.XLEN(32), .DEPTH(8), .ITER_LIMIT(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .curr_PC        (curr_pc),
    .instruction    (instruction),
    .immediate      (immediate),
    .mispredict     (mispredict),
    .block_signal   (block_signal),
    .flush          (flush),
    .redirect       (redirect),
    .new_pc         (new_pc),
    .out_instruction(out_instruction),
    .out_valid      (out_valid)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] imm;
    logic        mp;
    logic        ev;
    logic [31:0] eins;
    logic        eblk;
    logic        efl;
    logic        erd;
    logic [31:0] epc;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [31:0] imm, input logic mp,
                              input logic ev, input logic [31:0] eins, input logic eblk,
                              input logic efl, input logic erd, input logic [31:0] epc);
    vec_t t;
    t.rst = rst; t.v = v; t.pc = pc; t.ins = ins; t.imm = imm; t.mp = mp;
    t.ev = ev; t.eins = eins; t.eblk = eblk; t.efl = efl; t.erd = erd; t.epc = epc;
    vq.push_back(t);
  endfunction

  function automatic void pt(input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] imm);
    add(1'b0, 1'b1, pc, ins, imm, 1'b0, 1'b1, ins, 1'b0, 1'b0, 1'b0, 32'h0);
  endfunction

  function automatic void nop_none();
    add(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endfunction

  // Replay output expected; inputs are a capture-completing branch or idle.
  function automatic void rpb(input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] imm, input logic [31:0] eins,
                              input logic [31:0] epc);
    add(1'b0, 1'b1, pc, ins, imm, 1'b0, 1'b1, eins, 1'b1, 1'b0, 1'b0, epc);
  endfunction

  function automatic void rpi(input logic [31:0] eins, input logic [31:0] epc);
    add(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, eins, 1'b1, 1'b0, 1'b0, epc);
  endfunction

  function automatic void mpx(input logic [31:0] epc);
    add(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, epc);
  endfunction

  function automatic void lim(input logic [31:0] epc);
    add(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, epc);
  endfunction

  function automatic void rst_v();
    add(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", nm, cur, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    reset       = t.rst;
    in_valid    = t.v;
    curr_pc     = t.pc;
    instruction = t.ins;
    immediate   = t.imm;
    mispredict  = t.mp;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(t.ev));
    chk("block_signal", 32'(block_signal), 32'(t.eblk));
    chk("flush", 32'(flush), 32'(t.efl));
    chk("redirect", 32'(redirect), 32'(t.erd));
    if (t.ev || t.rst) chk("out_instruction", out_instruction, t.eins);
    if (t.eblk || t.erd || t.rst) chk("new_pc", new_pc, t.epc);
    cur++;
  endtask

  logic [31:0] body1 [4];
  logic [31:0] body2 [4];
  logic [31:0] body8 [8];

  initial begin
    reset = 1'b1; in_valid = 1'b0; mispredict = 1'b0;
    curr_pc = '0; instruction = '0; immediate = '0;
    body1 = '{32'h13, 32'h14, 32'h15, Br1};
    body2 = '{32'h21, 32'h22, 32'h23, Br2};
    for (int i = 0; i < 7; i++) body8[i] = 32'h1000 + 32'(i);
    body8[7] = Br1;

    // Reset, then capture and replay of the 0x100 loop, mispredict exit.
    rst_v();
    for (int i = 0; i < 4; i++) pt(32'h100 + 32'(4 * i), body1[i], (i == 3) ? M3 : 32'h0);
    for (int i = 0; i < 3; i++) pt(32'h100 + 32'(4 * i), body1[i], 32'h0);
    rpb(32'h10C, Br1, M3, 32'h13, 32'h100);
    for (int k = 1; k < 5; k++) rpi(body1[k % 4], 32'h100 + 32'(4 * (k % 4)));
    mpx(32'h110);

    // Fresh loop at 0x110 runs to the iteration limit: 12 replays then redirect to head.
    for (int i = 0; i < 4; i++) pt(32'h110 + 32'(4 * i), body2[i], (i == 3) ? M3 : 32'h0);
    for (int i = 0; i < 3; i++) pt(32'h110 + 32'(4 * i), body2[i], 32'h0);
    rpb(32'h11C, Br2, M3, 32'h21, 32'h110);
    for (int k = 1; k < 12; k++) rpi(body2[k % 4], 32'h110 + 32'(4 * (k % 4)));
    lim(32'h110);
    nop_none();

    // L = DEPTH+1 must never arm.
    pt(32'h300, Br1, M8);
    for (int i = 0; i < 8; i++) pt(32'h2E0 + 32'(4 * i), 32'h2000 + 32'(i), 32'h0);
    pt(32'h300, Br1, M8);
    nop_none();

    // L = DEPTH fills every entry and wraps after index DEPTH-1.
    pt(32'h41C, Br1, M7);
    for (int i = 0; i < 7; i++) pt(32'h400 + 32'(4 * i), body8[i], 32'h0);
    rpb(32'h41C, Br1, M7, body8[0], 32'h400);
    for (int k = 1; k < 9; k++) rpi(body8[k % 8], 32'h400 + 32'(4 * (k % 8)));
    mpx(32'h420);

    // PC jump mid-capture aborts silently; the branch then only re-arms.
    pt(32'h10C, Br1, M3);
    pt(32'h100, 32'h13, 32'h0);
    pt(32'h104, 32'h14, 32'h0);
    pt(32'h200, 32'h99, 32'h0);
    pt(32'h108, 32'h15, 32'h0);
    pt(32'h10C, Br1, M3);
    nop_none();

    // Bubbles during capture, then reset in the middle of replay.
    pt(32'h100, 32'h13, 32'h0);
    nop_none();
    pt(32'h104, 32'h14, 32'h0);
    nop_none();
    nop_none();
    pt(32'h108, 32'h15, 32'h0);
    nop_none();
    rpb(32'h10C, Br1, M3, 32'h13, 32'h100);
    for (int k = 1; k < 4; k++) rpi(body1[k], 32'h100 + 32'(4 * k));
    rst_v();

    foreach (vq[i]) apply(vq[i]);

    // Mispredict on the limit-wrap cycle: flush wins, target is br_pc + 4.
    vq.delete();
    for (int i = 0; i < 4; i++) pt(32'h100 + 32'(4 * i), body1[i], (i == 3) ? M3 : 32'h0);
    for (int i = 0; i < 3; i++) pt(32'h100 + 32'(4 * i), body1[i], 32'h0);
    rpb(32'h10C, Br1, M3, 32'h13, 32'h100);
    for (int k = 1; k < 12; k++) rpi(body1[k % 4], 32'h100 + 32'(4 * (k % 4)));
    mpx(32'h110);
    nop_none();
    foreach (vq[i]) apply(vq[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
